// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter.
// Vectors are sized for up to MaxSlaves requesters and narrowed by the callers.
package axis_arb_pkg;

    localparam int unsigned MaxSlaves = 32;
    localparam int unsigned MaxIdxW   = 5;

    typedef logic [MaxSlaves-1:0] req_vec_t;
    typedef logic [MaxIdxW-1:0]   idx_t;

    typedef enum logic {StIdle, StBusy} state_t;

    // First requester after ptr, wrapping at n; ptr itself is considered last.
    function automatic req_vec_t rr_pick(req_vec_t req, idx_t ptr, int unsigned n);
        req_vec_t gnt;
        idx_t     idx;
        gnt = '0;
        for (int unsigned k = 1; k <= MaxSlaves; k++) begin
            idx = idx_t'((32'(ptr) + k) % n);
            if (k <= n && req[idx] && gnt == '0) begin
                gnt[idx] = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic idx_t onehot2idx(req_vec_t oh);
        idx_t idx;
        idx = '0;
        for (int unsigned i = 0; i < MaxSlaves; i++) begin
            if (oh[idx_t'(i)]) idx = idx | idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin picker: rotate past ptr, priority-encode, unrotate.
module axis_rr_picker
    import axis_arb_pkg::*;
#(
    parameter int unsigned NSLAVES = 2,
    parameter int unsigned IdxW    = 1
) (
    input  logic [NSLAVES-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [NSLAVES-1:0] pick_o,
    output logic [IdxW-1:0]    pick_idx_o
);

    req_vec_t pick_full;
    idx_t     pick_idx_full;
    logic     unused_bits;

    always_comb begin
        pick_full     = rr_pick(req_vec_t'(req_i), idx_t'(ptr_i), NSLAVES);
        pick_idx_full = onehot2idx(pick_full);
        pick_o        = pick_full[NSLAVES-1:0];
        pick_idx_o    = pick_idx_full[IdxW-1:0];
    end

    // Upper bits beyond NSLAVES / IdxW are always zero.
    assign unused_bits = ^{pick_full, pick_idx_full};

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-aware round-robin arbiter for one AXI-Stream master shared by NSLAVES requesters.
// Define AXIS_ARB_STATS_EN to add saturating per-slave grant counters on port grant_cnt.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NSLAVES   = 2,
    parameter int unsigned HAS_LAST  = 0,
    parameter int unsigned MAX_BURST = 1,
    parameter int unsigned CNT_WIDTH = 16,
    localparam int unsigned IdxW     = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [NSLAVES-1:0] s_valid,
    input  logic [NSLAVES-1:0] s_last,
    output logic [NSLAVES-1:0] s_ready,
    input  logic               m_ready,
    output logic               m_valid,
    output logic [NSLAVES-1:0] grant,
    output logic [IdxW-1:0]    grant_idx,
    output logic               grant_valid
`ifdef AXIS_ARB_STATS_EN
    ,
    output logic [NSLAVES*CNT_WIDTH-1:0] grant_cnt
`endif
);

    localparam int unsigned BeatW = $clog2(MAX_BURST + 1);

    state_t             state_q, state_d;
    logic [NSLAVES-1:0] grant_q, grant_d, pick;
    logic [IdxW-1:0]    ptr_q, ptr_d, pick_idx;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic               beat, last_beat;

    axis_rr_picker #(
        .NSLAVES (NSLAVES),
        .IdxW    (IdxW)
    ) u_picker (
        .req_i      (s_valid),
        .ptr_i      (ptr_q),
        .pick_o     (pick),
        .pick_idx_o (pick_idx)
    );

    assign beat      = m_valid & m_ready;
    assign last_beat = (HAS_LAST != 0) ? |(s_last & grant_q)
                                       : (beat_q == BeatW'(MAX_BURST - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= IdxW'(NSLAVES - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (|s_valid) begin
                    grant_d = pick;
                    ptr_d   = pick_idx;
                    beat_d  = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (beat && last_beat) begin
                    beat_d = '0;
                    // Hand over on the same edge so there is no bubble between packets.
                    if (|s_valid) begin
                        grant_d = pick;
                        ptr_d   = pick_idx;
                    end else begin
                        grant_d = '0;
                        state_d = StIdle;
                    end
                end else if (beat) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant_valid = (state_q == StBusy);
        grant       = grant_q;
        grant_idx   = IdxW'(onehot2idx(req_vec_t'(grant_q)));
        m_valid     = |(s_valid & grant_q);
        s_ready     = grant_q & {NSLAVES{m_ready}};
    end

`ifdef AXIS_ARB_STATS_EN
    logic grant_evt;
    assign grant_evt = |s_valid && ((state_q == StIdle) || (beat && last_beat));

    for (genvar i = 0; i < NSLAVES; i++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q;
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                cnt_q <= '0;
            end else if (grant_evt && pick[i] && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
        assign grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end
`endif

endmodule
